freq_monitor: RTL and testbench
===============================

# freq_monitor

Receive-side companion to the clock divider. It samples a divided, toggling clock (the divider's output) in the source-clock domain and turns each toggle into a one-cycle strobe. It measures every half-period in source-clock cycles and reports whether the divided clock runs at its expected rate. Downstream traffic-light sequencing logic uses `tick` as its clock enable and `locked` as its go/no-go status.

## Interface
Parameters:
- `K`, 5: expected half-period of `F2_in`, in `F1` cycles; same meaning as the divider's `K`, so must equal the value on the divider being monitored.
- `TOL`, 0: allowed deviation; a half-period `m` is good iff `K-TOL <= m <= K+TOL`.
- `LOCK_CNT`, 4: consecutive good half-periods required to lock, ≥1.
- `CW`, 32: width of the cycle counter and `period`.

Ports:
- `F1` in 1: the one clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `F2_in` in 1: divided clock to monitor; asynchronous to `F1` phase.
- `tick` out 1: one-cycle pulse per detected edge of `F2_in` (rising or falling).
- `rise` out 1: one-cycle pulse per detected rising edge.
- `fall` out 1: one-cycle pulse per detected falling edge.
- `period` out CW: last measured half-period, in `F1` cycles.
- `locked` out 1: high while in LOCKED.
- `err` out 1: one-cycle pulse on mismatch or timeout.
- `err_cnt` out 8: saturating count of `err` pulses.

## Operation
- Input path: 3-stage register chain `s1<-F2_in`, `s2<-s1`, `s3<-s2`. Detected edge is `e = s2^s3`; rise is `s2&~s3`; fall is `~s2&s3`.
- Cycle counter `cnt`, CW bits:
  - On an `e` cycle: `cnt<=0`, and the measurement `m = cnt+1`.
  - Otherwise: `cnt<=cnt+1`, saturating at all-ones.
- FSM states:
  - SEARCH (reset state): no reference edge yet.
    - First `e` → TRAIN, `good<=0`.
    - `period` is not updated. No timeout in this state.
  - TRAIN, on `e`:
    - `period<=m`.
    - If `m` is good: `good<=good+1`. When the new value equals LOCK_CNT → LOCKED.
    - If `m` is bad: `good<=0`, `err` pulse, stay in TRAIN.
  - LOCKED, on `e`:
    - `period<=m`.
    - If `m` is good: stay.
    - If `m` is bad: `err` pulse → TRAIN, `good<=0`.
  - Timeout (TRAIN or LOCKED only): a non-`e` cycle where `cnt+1 == 4*K` → `err` pulse → SEARCH, `good<=0`.
- Simultaneous events: an `e` cycle never times out; the edge is processed as above.
- `err_cnt` increments on every `err` pulse and holds at 255.
- `tick`, `rise`, `fall` are produced in every state, including SEARCH.

## Timing
- Reset (`rst_n` low at a posedge): all of the following are 0:
  - `s1`, `s2`, `s3`, `cnt`, `good`
  - `tick`, `rise`, `fall`, `period`, `locked`, `err`, `err_cnt`
  - State returns to SEARCH.
  - Reset asserted mid-operation behaves identically to reset at power-up.
- Reset release with `F2_in` already high: this yields a `rise`/`tick` 3 cycles later. The FSM treats it as the first SEARCH edge.
- Latency: `F2_in` changes and is stable before posedge P. Then `tick`/`rise`/`fall` are high for exactly the cycle following posedge P+2.
- `period`, `locked`, `err` are all registered and update on the same posedge that raises the corresponding `tick`.
- Minimum resolvable half-period is 2 `F1` cycles; shorter pulses may be missed. That case is outside the requirement.
- With an ideal divider (edges exactly K cycles apart), every `m = K`.

## Test plan
- Lock-in, K=5, LOCK_CNT=4: drive an ideal toggle with half-period 5 after reset.
  - First `tick` changes nothing else.
  - The next 4 ticks show `period=5`.
  - `locked` rises on the 4th of those ticks.
  - `err` is never asserted.
- Mismatch while LOCKED: after lock, stretch one half-period to 7.
  - On that tick: `period=7`, one-cycle `err`, `locked=0`, `err_cnt=1`.
  - It relocks after 4 further good half-periods.
- Timeout: after lock, hold `F2_in` constant.
  - Exactly 20 cycles after the last edge's tick cycle: `err` pulse, `locked=0`, state SEARCH.
  - The next edge does not update `period`.
- Tolerance, TOL=1: alternate half-periods of 4 and 6 → locks, no `err`. Then a half-period of 3 → `err`.
- Reset mid-TRAIN and at reset-with-input-high:
  - All outputs read 0 the cycle after reset.
  - With `F2_in=1` at reset release: `rise` 3 cycles after release, `period` stays 0.
- Saturation: force 260 mismatches → `err_cnt` holds at 255.

Source files
------------

// File: rtl/freq_monitor.sv
// Measures the half-period of a divided clock sampled in the F1 domain and
// emits per-edge strobes, the last half-period, and a lock/error status.
module freq_monitor #(
    parameter int unsigned K        = 5,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CW       = 32
) (
    input  logic          F1,
    input  logic          rst_n,
    input  logic          F2_in,
    output logic          tick,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] period,
    output logic          locked,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam int unsigned GW  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int unsigned LO  = (K > TOL) ? (K - TOL) : 0;
    localparam int unsigned HI  = K + TOL;
    localparam int unsigned TMO = 4 * K;

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

    state_t          state;
    logic            s1, s2, s3;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   good;

    logic            e_c;
    logic [CW-1:0]   m_c;
    logic            good_c;
    logic            tmo_c;
    logic            err_c;
    logic [GW-1:0]   good_inc_c;

    // Edge detect, measurement and error qualification for the current cycle
    always_comb begin
        e_c        = s2 ^ s3;
        m_c        = cnt + CW'(1);
        good_c     = (m_c >= CW'(LO)) && (m_c <= CW'(HI));
        tmo_c      = !e_c && (state != SEARCH) && (m_c == CW'(TMO));
        err_c      = (e_c && (state != SEARCH) && !good_c) || tmo_c;
        good_inc_c = good + GW'(1);
    end

    always_ff @(posedge F1) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            cnt     <= '0;
            good    <= '0;
            state   <= SEARCH;
            tick    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            period  <= '0;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            s1   <= F2_in;
            s2   <= s1;
            s3   <= s2;
            tick <= e_c;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
            err  <= err_c;

            if (err_c && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            // Counter restarts on each edge and parks at all-ones if the input stalls
            if (e_c) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= m_c;
            end

            if (tmo_c) begin
                state  <= SEARCH;
                good   <= '0;
                locked <= 1'b0;
            end else if (e_c) begin
                case (state)
                    SEARCH: begin
                        state <= TRAIN;
                        good  <= '0;
                    end
                    TRAIN: begin
                        period <= m_c;
                        if (good_c) begin
                            good <= good_inc_c;
                            if (good_inc_c == GW'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end
                    LOCKED: begin
                        period <= m_c;
                        if (!good_c) begin
                            state  <= TRAIN;
                            good   <= '0;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state <= SEARCH;
                        good  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_monitor.sv
// Directed bench for freq_monitor: lock-in, mismatch, timeout, tolerance,
// reset behaviour and error-counter saturation.
module tb_freq_monitor;

    logic        clk;
    logic        rst_n;
    logic        f2;
    logic        f2t;

    logic        tick, rise, fall, locked, err;
    logic [31:0] period;
    logic [7:0]  err_cnt;

    logic        t_tick, t_rise, t_fall, t_locked, t_err;
    logic [31:0] t_period;
    logic [7:0]  t_err_cnt;

    int checks = 0;
    int errors = 0;
    int since  = 0;

    freq_monitor #(.K(5), .TOL(0), .LOCK_CNT(4), .CW(32)) dut (
        .F1(clk), .rst_n(rst_n), .F2_in(f2),
        .tick(tick), .rise(rise), .fall(fall), .period(period),
        .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    freq_monitor #(.K(5), .TOL(1), .LOCK_CNT(4), .CW(32)) dut_t (
        .F1(clk), .rst_n(rst_n), .F2_in(f2t),
        .tick(t_tick), .rise(t_rise), .fall(t_fall), .period(t_period),
        .locked(t_locked), .err(t_err), .err_cnt(t_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after posedge
    task automatic cyc();
        @(posedge clk);
        #1;
        since++;
    endtask

    // Toggle the selected input n cycles after its previous toggle, then
    // advance to the cycle in which the resulting tick is visible
    task automatic next_edge(input int n, input bit which);
        while (since < n) cyc();
        if (which) f2t = ~f2t;
        else       f2  = ~f2;
        since = 0;
        repeat (3) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        f2    = 1'b0;
        f2t   = 1'b0;
        repeat (3) cyc();

        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_rise", 32'(rise), 32'd0);
        chk("rst_fall", 32'(fall), 32'd0);
        chk("rst_period", period, 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        rst_n = 1'b1;
        repeat (4) cyc();

        // Lock-in: first edge only arms the measurement
        f2    = 1'b1;
        since = 0;
        repeat (3) cyc();
        chk("first_tick", 32'(tick), 32'd1);
        chk("first_rise", 32'(rise), 32'd1);
        chk("first_period", period, 32'd0);
        chk("first_locked", 32'(locked), 32'd0);
        chk("first_err", 32'(err), 32'd0);
        cyc();
        chk("tick_one_cycle", 32'(tick), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            next_edge(5, 1'b0);
            chk("lock_tick", 32'(tick), 32'd1);
            chk("lock_period", period, 32'd5);
            chk("lock_locked", 32'(locked), 32'(i == 4));
            chk("lock_err", 32'(err), 32'd0);
            if (i == 1) chk("lock_fall", 32'(fall), 32'd1);
        end

        // Mismatch while locked
        next_edge(7, 1'b0);
        chk("mis_period", period, 32'd7);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_locked", 32'(locked), 32'd0);
        chk("mis_err_cnt", 32'(err_cnt), 32'd1);
        cyc();
        chk("mis_err_pulse", 32'(err), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            next_edge(5, 1'b0);
            chk("relock_locked", 32'(locked), 32'(i == 4));
            chk("relock_err", 32'(err), 32'd0);
        end
        chk("relock_err_cnt", 32'(err_cnt), 32'd1);

        // Timeout: input held, err lands 20 cycles after the last tick cycle
        while (since < 22) cyc();
        chk("tmo_pre_err", 32'(err), 32'd0);
        chk("tmo_pre_locked", 32'(locked), 32'd1);
        cyc();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_locked", 32'(locked), 32'd0);
        chk("tmo_err_cnt", 32'(err_cnt), 32'd2);

        next_edge(30, 1'b0);
        chk("search_tick", 32'(tick), 32'd1);
        chk("search_period", period, 32'd5);
        chk("search_err", 32'(err), 32'd0);
        next_edge(6, 1'b0);
        chk("train_period", period, 32'd6);
        chk("train_err", 32'(err), 32'd1);
        chk("train_err_cnt", 32'(err_cnt), 32'd3);

        // Reset mid-TRAIN, then release with the input already high
        next_edge(5, 1'b0);
        rst_n = 1'b0;
        f2    = 1'b1;
        cyc();
        chk("mrst_tick", 32'(tick), 32'd0);
        chk("mrst_period", period, 32'd0);
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        cyc();
        rst_n = 1'b1;
        since = 0;
        repeat (2) cyc();
        chk("rel_rise_early", 32'(rise), 32'd0);
        cyc();
        chk("rel_rise", 32'(rise), 32'd1);
        chk("rel_tick", 32'(tick), 32'd1);
        chk("rel_period", period, 32'd0);
        next_edge(5, 1'b0);
        chk("rel_first_period", period, 32'd5);

        // Saturation of the error counter with back-to-back short half-periods
        for (int i = 0; i < 260; i++) begin
            next_edge(4, 1'b0);
            if (i == 100) chk("sat_mid", 32'(err_cnt), 32'd101);
        end
        chk("sat_err", 32'(err), 32'd1);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Tolerance of +/-1 on the second instance
        f2t   = 1'b1;
        since = 0;
        repeat (3) cyc();
        chk("tol_first_rise", 32'(t_rise), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            next_edge((i % 2 == 1) ? 4 : 6, 1'b1);
            chk("tol_period", t_period, (i % 2 == 1) ? 32'd4 : 32'd6);
            chk("tol_err", 32'(t_err), 32'd0);
            chk("tol_locked", 32'(t_locked), 32'(i >= 4));
            if (i == 1) chk("tol_fall", 32'(t_fall), 32'd1);
        end
        next_edge(3, 1'b1);
        chk("tol_bad_tick", 32'(t_tick), 32'd1);
        chk("tol_bad_period", t_period, 32'd3);
        chk("tol_bad_err", 32'(t_err), 32'd1);
        chk("tol_bad_locked", 32'(t_locked), 32'd0);
        chk("tol_bad_err_cnt", 32'(t_err_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
